alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Execute-stage ALU that sits directly downstream of ALU control.
- Consumes the 4-bit ALU select code and two operands, and produces the result plus branch flags (zero/negative/carry/overflow).
- Logic and arithmetic ops complete in one cycle. Shifts are iterative, one bit per cycle, to save area on RV32IC.
- Operands and results move on a valid/ready handshake so the pipeline can stall on long shifts.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept; high only in IDLE.
- alus  in  4  ALU select code (ALU_* codes from defines.v).
- op_a  in  XLEN  operand A (rs1).
- op_b  in  XLEN  operand B (rs2/imm); shift amount = op_b[SHW-1:0].
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  ALU result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[XLEN-1].
- flag_c  out  1  ADD: carry-out; SUB: no-borrow (op_a >= op_b unsigned); else 0.
- flag_v  out  1  ADD/SUB signed overflow; else 0.
- op_err  out  1  alus was not a defined ALU_* code.

Behaviour:
- Reset:
  - state=IDLE; in_ready=1 from the first cycle after reset.
  - out_valid=0; result, all flags and op_err = 0.
  - rst overrides every other input.
- State machine (IDLE, SHIFT, DONE):
  - IDLE:
    - in_valid=1 -> capture alus/op_a/op_b.
    - Non-shift op -> compute and register result/flags; go to DONE.
    - Shift op with shamt=0 -> result=op_a; go to DONE.
    - Shift op with shamt>0 -> load working register=op_a and counter=shamt; go to SHIFT.
  - SHIFT:
    - Each cycle shift the working register by 1: SLL left with zero fill; SRL right with zero fill; SRA right with sign replicate. Decrement counter.
    - When counter reaches 1, the final shift is done that cycle; register result/flags; go to DONE.
  - DONE:
    - out_valid=1; result and flags held stable.
    - out_ready=1 -> go to IDLE; out_valid drops next cycle.
- Latency (accept edge = cycle 0):
  - non-shift or shamt=0: out_valid at cycle 1.
  - shamt=n: out_valid at cycle n+1. Max XLEN (32 for shamt=31).
- Throughput: no overlap; in_ready=0 in SHIFT and DONE. Minimum 2 cycles per op under continuous out_ready.
- Arithmetic:
  - ADD/SUB use an XLEN+1-bit sum. SUB = A + ~B + 1.
  - SLT signed, SLTU unsigned; result = {XLEN-1 zeros, cmp}.
  - Flags are computed on the final result for every op; c/v apply to ADD/SUB only.
- Undefined alus: result=0, flag_z=1, op_err=1, latency 1.
- in_valid outside IDLE is ignored; the upstream stage holds it.
- Reset mid-SHIFT or mid-DONE: operation discarded; IDLE next cycle; no out_valid pulse.
- Outputs are registered; there is no combinational path from in_* to out_*.

Optional Feature:
- ALU_FAST_SHIFT_EN defined: shifts use a single-cycle barrel shifter. SHIFT state and counter are not built. All ops have latency 1.
- Undefined (default): iterative 1-bit-per-cycle shifting as above.

Decomposition:
- ALU_* select codes and F3_* constants stay in the shared defines.v package. Add the state encodings IDLE/SHIFT/DONE there.
- One natural sub-module: alu_comb_core. It is purely combinational: ADD/SUB/AND/OR/XOR/SLT/SLTU plus flag generation, and is reused for single-cycle ops.
- The FSM, shift register and counter stay in alu_iter_exec.

Test Plan:
- ADD, a=0x7FFFFFFF, b=1 -> cycle 1: result=0x80000000, v=1, n=1, c=0, z=0.
- SUB, a=5, b=5 -> result=0, z=1, c=1, v=0. SLTU, a=1, b=0xFFFFFFFF -> result=1.
- SRA, a=0x80000000, b=31 -> out_valid exactly at cycle 32, result=0xFFFFFFFF; in_ready=0 throughout. With ALU_FAST_SHIFT_EN -> cycle 1.
- SLL, a=0x1, b=0 -> cycle 1, result=0x1. SRL, a=0xF0, b=4 -> cycle 5, result=0xF.
- out_ready held 0 for 10 cycles in DONE -> result/flags stable, in_ready=0. out_ready=1 -> IDLE; next op accepted one cycle later.
- rst asserted at cycle 3 of SLL by 20 -> next cycle IDLE, out_valid stays 0. Undefined alus (code not in defines) -> op_err=1, result=0.

Source files
------------

// File: rtl/alu_iter_exec_pkg.sv
// Shared ALU select codes, FSM state encodings and small helpers for the execute-stage ALU.
package alu_iter_exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_iter_exec_if.sv
// Operand/result valid-ready bundle between ALU control, the execute ALU and its consumer.
interface alu_iter_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alus;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            flag_z;
  logic            flag_n;
  logic            flag_c;
  logic            flag_v;
  logic            op_err;

  modport master (
    output in_valid, alus, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, op_err
  );

  modport slave (
    input  in_valid, alus, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, op_err
  );
endinterface

// File: rtl/alu_iter_exec_comb_core.sv
// Purely combinational single-cycle ALU ops with flag generation; shift codes report op_err here.
module alu_comb_core
  import alu_iter_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alus,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            flag_z,
  output logic            flag_n,
  output logic            flag_c,
  output logic            flag_v,
  output logic            op_err
);
  logic            is_sub;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;

  // SUB is A + ~B + 1, so the carry-out doubles as the no-borrow flag.
  assign is_sub = (alus == ALU_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};

  always_comb begin
    result = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    op_err = 1'b0;
    case (alus)
      ALU_ADD, ALU_SUB: begin
        result = sum[XLEN-1:0];
        flag_c = sum[XLEN];
        flag_v = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  op_err = 1'b1;
    endcase
  end

  assign flag_z = ~|result;
  assign flag_n = result[XLEN-1];

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arith, iterative 1-bit/cycle shifts, valid/ready on both sides.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_iter_exec
  import alu_iter_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_iter_exec_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  state_e          state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            z_reg, z_next, n_reg, n_next, c_reg, c_next, v_reg, v_next;
  logic            err_reg, err_next;

  logic [XLEN-1:0] core_result;
  logic            core_z, core_n, core_c, core_v, core_err;
  logic [SHW-1:0]  shamt;

  assign shamt = bus.op_b[SHW-1:0];

  alu_comb_core #(.XLEN(XLEN)) u_core (
    .alus   (bus.alus),
    .a      (bus.op_a),
    .b      (bus.op_b),
    .result (core_result),
    .flag_z (core_z),
    .flag_n (core_n),
    .flag_c (core_c),
    .flag_v (core_v),
    .op_err (core_err)
  );

`ifdef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0] barrel;

  always_comb begin
    barrel = bus.op_a;
    case (bus.alus)
      ALU_SLL: barrel = bus.op_a << shamt;
      ALU_SRL: barrel = bus.op_a >> shamt;
      ALU_SRA: barrel = XLEN'($signed(bus.op_a) >>> shamt);
      default: barrel = bus.op_a;
    endcase
  end
`else
  logic [XLEN-1:0] work_reg, work_next, work_shifted;
  logic [SHW-1:0]  cnt_reg, cnt_next;
  logic [3:0]      shop_reg, shop_next;

  always_comb begin
    work_shifted = work_reg;
    case (shop_reg)
      ALU_SLL: work_shifted = {work_reg[XLEN-2:0], 1'b0};
      ALU_SRL: work_shifted = {1'b0, work_reg[XLEN-1:1]};
      ALU_SRA: work_shifted = {work_reg[XLEN-1], work_reg[XLEN-1:1]};
      default: work_shifted = work_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg <= '0;
      cnt_reg  <= '0;
      shop_reg <= '0;
    end else begin
      work_reg <= work_next;
      cnt_reg  <= cnt_next;
      shop_reg <= shop_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      z_reg      <= 1'b0;
      n_reg      <= 1'b0;
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      z_reg      <= z_next;
      n_reg      <= n_next;
      c_reg      <= c_next;
      v_reg      <= v_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    z_next      = z_reg;
    n_next      = n_reg;
    c_next      = c_reg;
    v_next      = v_reg;
    err_next    = err_reg;
`ifndef ALU_FAST_SHIFT_EN
    work_next   = work_reg;
    cnt_next    = cnt_reg;
    shop_next   = shop_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = DONE;
          if (is_shift(bus.alus)) begin
            c_next   = 1'b0;
            v_next   = 1'b0;
            err_next = 1'b0;
`ifdef ALU_FAST_SHIFT_EN
            result_next = barrel;
            z_next      = ~|barrel;
            n_next      = barrel[XLEN-1];
`else
            if (shamt == '0) begin
              result_next = bus.op_a;
              z_next      = ~|bus.op_a;
              n_next      = bus.op_a[XLEN-1];
            end else begin
              work_next  = bus.op_a;
              cnt_next   = shamt;
              shop_next  = bus.alus;
              state_next = SHIFT;
            end
`endif
          end else begin
            result_next = core_result;
            z_next      = core_z;
            n_next      = core_n;
            c_next      = core_c;
            v_next      = core_v;
            err_next    = core_err;
          end
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        work_next = work_shifted;
        cnt_next  = cnt_reg - {{(SHW-1){1'b0}}, 1'b1};
        // Counter at 1 means this cycle performs the last shift.
        if (cnt_reg == {{(SHW-1){1'b0}}, 1'b1}) begin
          result_next = work_shifted;
          z_next      = ~|work_shifted;
          n_next      = work_shifted[XLEN-1];
          state_next  = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.flag_z    = z_reg;
  assign bus.flag_n    = n_reg;
  assign bus.flag_c    = c_reg;
  assign bus.flag_v    = v_reg;
  assign bus.op_err    = err_reg;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed corner cases, then random ops against a reference model.
module tb_alu_iter_exec;
  import alu_iter_exec_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_iter_exec_if #(.XLEN(XLEN)) bus ();

  alu_iter_exec #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        z, n, c, v, err;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint t;
    logic [32:0] s;
    int     sh;
    sh    = int'(b[4:0]);
    e.res = 32'h0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      4'd0: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c   = s[32];
        t     = longint'($signed(a)) + longint'($signed(b));
        e.v   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd1: begin
        e.res = a - b;
        e.c   = (a >= b);
        t     = longint'($signed(a)) - longint'($signed(b));
        e.v   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd7, 4'd8, 4'd9: begin
        if (op == 4'd7)      e.res = a << sh;
        else if (op == 4'd8) e.res = a >> sh;
        else                 e.res = 32'($signed(a) >>> sh);
`ifndef ALU_FAST_SHIFT_EN
        e.lat = sh + 1;
`endif
      end
      default: e.err = 1'b1;
    endcase
    e.z = (e.res == 32'h0);
    e.n = e.res[31];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exp_t        e;
    int          n;
    bit          busy_bad;
    bit          hold_bad;
    logic [36:0] snap;
    e = model(op, a, b);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.alus     = op;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.alus     = 4'($urandom);
    n        = 1;
    busy_bad = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(e.lat));
    check({tag, "_busy_ready"}, 32'(busy_bad), 32'd0);
    check({tag, "_res"}, bus.result, e.res);
    check({tag, "_flags_zncve"}, {27'd0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err},
          {27'd0, e.z, e.n, e.c, e.v, e.err});
    $display("op=%0d a=%h b=%h -> res=%h z%0b n%0b c%0b v%0b err%0b lat=%0d", op, a, b,
             bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err, n);
    if (hold > 0) begin
      snap     = {bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err};
      hold_bad = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err} !== snap ||
            bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) hold_bad = 1'b1;
      end
      check({tag, "_hold"}, 32'(hold_bad), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_back_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    bit          ghost;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alus      = 4'd0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {27'd0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err}, 32'd0);

    run_op("add_ovf", ALU_ADD, 32'h7FFFFFFF, 32'h1, 0);
    run_op("sub_eq", ALU_SUB, 32'd5, 32'd5, 0);
    run_op("sltu", ALU_SLTU, 32'd1, 32'hFFFFFFFF, 0);
    run_op("slt", ALU_SLT, 32'hFFFFFFFF, 32'd1, 0);
    run_op("sra31", ALU_SRA, 32'h80000000, 32'd31, 0);
    run_op("sll0", ALU_SLL, 32'h1, 32'd0, 0);
    run_op("srl4", ALU_SRL, 32'hF0, 32'd4, 0);
    run_op("xor_hold", ALU_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000, 10);
    run_op("undef", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("undef15", 4'd15, 32'hFFFFFFFF, 32'h1, 0);

    // Reset three cycles into a long shift must discard the operation.
    while (bus.in_ready !== 1'b1) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.alus     = ALU_SLL;
    bus.op_a     = 32'h1;
    bus.op_b     = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    ghost = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) ghost = 1'b1;
    end
    check("midrst_no_pulse", 32'(ghost), 32'd0);
    $display("mid-shift reset: in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 5 == 0) ra = 32'h8000_0000;
      if (i % 7 == 0) rb = ra;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, (i % 6 == 0) ? 3 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
